forward_ctrl: RTL and testbench
===============================

FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 Parameter REG_W, default 5, register-specifier width.
REQ-002 Parameter CNT_W, default 16, stall-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 id_valid  input  1  instruction in ID is real (not bubble).
REQ-006 id_rs / id_rt  input  REG_W  source specifiers of the ID instruction.
REQ-007 id_rd  input  REG_W  destination specifier of the ID instruction.
REQ-008 id_regwrite / id_memread / id_alusrc  input  1  ID control bits: writes a register, is a load, operand B is the immediate.
REQ-009 flush  input  1  branch/jump taken; kill the ID instruction.
REQ-010 ForwardA  output  2  operand-A select for the EX instruction.
REQ-011 ForwardB  output  2  operand-B select for the EX instruction.
REQ-012 stall  output  1  load-use hazard; freeze PC and IF/ID.
REQ-013 stall_count  output  CNT_W  saturating count of stall cycles.

Function
REQ-014 The block SHALL hold three internal stage records, EX, MEM and WB, each containing rs, rt, rd, regwrite, memread and alusrc.
REQ-015 Every cycle: WB<=MEM and MEM<=EX. EX<=ID fields, or a bubble (all control bits 0, specifiers 0) when flush, stall or !id_valid.
REQ-016 Select encoding, fixed: 0 = register-file data, 1 = MEM/WB writeback data, 2 = EX/MEM ALU result, 3 = sign-extended immediate.
REQ-017 ForwardA SHALL be 2 if MEM.regwrite && !MEM.memread && MEM.rd!=0 && MEM.rd==EX.rs; else 1 if WB.regwrite && WB.rd!=0 && WB.rd==EX.rs; else 0.
REQ-018 ForwardA SHALL never be 3.
REQ-019 ForwardB SHALL be 3 when EX.alusrc. Otherwise it follows REQ-017's rule with EX.rt in place of EX.rs.
REQ-020 ForwardA/ForwardB SHALL be combinational from the stage records only, with no path from ID inputs.
REQ-021 stall SHALL be 1 when all of the following hold: id_valid && !flush && EX.memread && EX.rd!=0 && (EX.rd==id_rs || EX.rd==id_rt).
REQ-022 stall SHALL last exactly one cycle per load-use pair. After the bubble the load sits in MEM, and the consumer is released with select 1 in its EX cycle.
REQ-023 flush and hazard in the same cycle: flush wins, stall=0, EX loaded with bubble, stall_count unchanged.
REQ-024 stall_count SHALL increment by 1 on each cycle with stall=1 and saturate at all-ones.
REQ-025 Register 0 SHALL never produce a forward or a stall.

Reset
REQ-026 On rst_n low, all stage records SHALL immediately become bubbles and stall_count SHALL become 0. ForwardA, ForwardB and stall therefore read 0, including reset asserted mid-stall.
REQ-027 The first rising edge after rst_n deasserts SHALL capture ID normally.

Structure
REQ-028 The select encodings (REQ-016) and the bubble record value SHALL live in the shared pipeline package.
REQ-029 One sub-module, fwd_sel, SHALL compute one 2-bit select from a source specifier and the MEM/WB records. It is instantiated twice (A and B), with the alusrc override applied outside it.

Verification
REQ-030 add r3 (ID) then sub using r3 as rs the next cycle -> ForwardA=2 in sub's EX cycle, stall=0.
REQ-031 add r3, nop, and r3 as rt -> ForwardB=1; both MEM and WB writing r3 -> ForwardA=2 (MEM priority).
REQ-032 lw r5, then add using r5 -> stall=1 for exactly one cycle, stall_count 0->1, then ForwardA=1 in add's EX cycle.
REQ-033 lw r5 hazard with flush=1 in the same cycle -> stall=0, stall_count unchanged, next EX record is a bubble.
REQ-034 Writes to r0 followed by reads of r0 -> ForwardA=ForwardB=0, stall=0. alusrc=1 with an rt match -> ForwardB=3.
REQ-035 rst_n pulled low during stall=1 -> stall, ForwardA, ForwardB and stall_count are 0 before the next clock edge. Count saturation is forced with CNT_W=2 -> holds at 3.

Source files
------------

// File: rtl/forward_ctrl_pkg.sv
// Shared pipeline definitions for the forwarding/hazard controller:
// operand select encodings and the bubble value of a stage record.
package forward_ctrl_pkg;

  typedef enum logic [1:0] {
    SEL_RF    = 2'd0,
    SEL_WB    = 2'd1,
    SEL_EXMEM = 2'd2,
    SEL_IMM   = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic alusrc;
  } ctrl_t;

  // A bubble carries no control and zero specifiers; specifier width is
  // set by the instantiating module, so only its value lives here.
  localparam ctrl_t       CTRL_BUBBLE = '{regwrite: 1'b0, memread: 1'b0, alusrc: 1'b0};
  localparam int unsigned SPEC_BUBBLE = 0;

endpackage

// File: rtl/forward_ctrl_if.sv
// ID-stage request and forwarding/stall response bundle of forward_ctrl.
interface forward_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic             id_alusrc;
  logic             flush;
  logic [1:0]       ForwardA;
  logic [1:0]       ForwardB;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_regwrite, id_memread, id_alusrc, flush,
    input  ForwardA, ForwardB, stall, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_regwrite, id_memread, id_alusrc, flush,
    output ForwardA, ForwardB, stall, stall_count
  );
endinterface

// File: rtl/forward_ctrl_fwd_sel.sv
// One operand's forward select from the MEM and WB records; MEM wins.
module fwd_sel
  import forward_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] mem_rd,
  input  ctrl_t            mem_ctrl,
  input  logic [REG_W-1:0] wb_rd,
  input  ctrl_t            wb_ctrl,
  output fwd_sel_e         sel
);

  // A load in MEM has no ALU result worth forwarding yet.
  always_comb begin
    sel = SEL_RF;
    if (mem_ctrl.regwrite && !mem_ctrl.memread && (mem_rd != '0) && (mem_rd == src))
      sel = SEL_EXMEM;
    else if (wb_ctrl.regwrite && (wb_rd != '0) && (wb_rd == src))
      sel = SEL_WB;
  end

endmodule

// File: rtl/forward_ctrl.sv
// EX/MEM/WB shadow records driving operand forwarding selects and the
// load-use stall, with a saturating stall counter.
module forward_ctrl
  import forward_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  forward_ctrl_if.slave bus
);

  localparam int NUM_OPS = 2;

  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    ctrl_t            ctrl;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '{
    rs:   REG_W'(SPEC_BUBBLE),
    rt:   REG_W'(SPEC_BUBBLE),
    rd:   REG_W'(SPEC_BUBBLE),
    ctrl: CTRL_BUBBLE
  };

  stage_t           ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard, stall;

  logic [NUM_OPS-1:0][REG_W-1:0] src;
  fwd_sel_e                      sel [NUM_OPS];

  assign src[0] = ex_q.rs;
  assign src[1] = ex_q.rt;

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_sel
    fwd_sel #(.REG_W(REG_W)) u_sel (
      .src      (src[i]),
      .mem_rd   (mem_q.rd),
      .mem_ctrl (mem_q.ctrl),
      .wb_rd    (wb_q.rd),
      .wb_ctrl  (wb_q.ctrl),
      .sel      (sel[i])
    );
  end

  assign bus.ForwardA = sel[0];
  assign bus.ForwardB = ex_q.ctrl.alusrc ? SEL_IMM : sel[1];

  // Flush kills the consumer, so a hazard under flush needs no stall.
  assign hazard = bus.id_valid && ex_q.ctrl.memread && (ex_q.rd != '0) &&
                  ((ex_q.rd == bus.id_rs) || (ex_q.rd == bus.id_rt));
  assign stall  = hazard && !bus.flush;

  assign bus.stall       = stall;
  assign bus.stall_count = cnt_q;

  always_comb begin
    mem_d = ex_q;
    wb_d  = mem_q;
    ex_d  = STAGE_BUBBLE;
    if (bus.id_valid && !bus.flush && !stall) begin
      ex_d.rs            = bus.id_rs;
      ex_d.rt            = bus.id_rt;
      ex_d.rd            = bus.id_rd;
      ex_d.ctrl.regwrite = bus.id_regwrite;
      ex_d.ctrl.memread  = bus.id_memread;
      ex_d.ctrl.alusrc   = bus.id_alusrc;
    end
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= STAGE_BUBBLE;
      mem_q <= STAGE_BUBBLE;
      wb_q  <= STAGE_BUBBLE;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed scenarios for forward_ctrl: forwarding priority, load-use stall,
// flush override, r0, alusrc, async reset and counter saturation.
module tb_forward_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  forward_ctrl_if #(.REG_W(5), .CNT_W(16)) bus ();
  forward_ctrl_if #(.REG_W(5), .CNT_W(2))  sbus ();

  forward_ctrl #(.REG_W(5), .CNT_W(16)) dut     (.clk(clk), .rst_n(rst_n), .bus(bus));
  forward_ctrl #(.REG_W(5), .CNT_W(2))  dut_sat (.clk(clk), .rst_n(rst_n), .bus(sbus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic rw, input logic mr, input logic as);
    bus.id_valid = v; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.id_regwrite = rw; bus.id_memread = mr; bus.id_alusrc = as;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    bus.flush = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    #1;
    n_chk++; if (bus.ForwardA !== 2'd0) begin n_fail++; $display("FAIL reset_fa: got %0d exp 0", bus.ForwardA); end
    n_chk++; if (bus.ForwardB !== 2'd0) begin n_fail++; $display("FAIL reset_fb: got %0d exp 0", bus.ForwardB); end
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0d exp 0", bus.stall); end
    n_chk++; if (bus.stall_count !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d exp 0", bus.stall_count); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fwd_mem();
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);   // add r3, r1, r2
    tick();
    set_id(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 1'b0);   // sub r6, r3, r4
    tick();
    n_chk++; if (bus.ForwardA !== 2'd2) begin n_fail++; $display("FAIL mem_fa: got %0d exp 2", bus.ForwardA); end
    n_chk++; if (bus.ForwardB !== 2'd0) begin n_fail++; $display("FAIL mem_fb: got %0d exp 0", bus.ForwardB); end
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL mem_stall: got %0d exp 0", bus.stall); end
    drain();
  endtask

  task automatic test_fwd_wb();
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);   // add r3
    tick();
    nop();
    tick();
    set_id(1'b1, 5'd7, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0);   // reads r3 as rt
    tick();
    n_chk++; if (bus.ForwardB !== 2'd1) begin n_fail++; $display("FAIL wb_fb: got %0d exp 1", bus.ForwardB); end
    n_chk++; if (bus.ForwardA !== 2'd0) begin n_fail++; $display("FAIL wb_fa: got %0d exp 0", bus.ForwardA); end
    drain();
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);   // add r3 (older)
    tick();
    set_id(1'b1, 5'd4, 5'd5, 5'd3, 1'b1, 1'b0, 1'b0);   // add r3 (newer)
    tick();
    set_id(1'b1, 5'd3, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    n_chk++; if (bus.ForwardA !== 2'd2) begin n_fail++; $display("FAIL prio_fa: got %0d exp 2", bus.ForwardA); end
    n_chk++; if (bus.ForwardB !== 2'd2) begin n_fail++; $display("FAIL prio_fb: got %0d exp 2", bus.ForwardB); end
    drain();
  endtask

  task automatic test_load_use();
    set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1);   // lw r5, 0(r1)
    tick();
    n_chk++; if (bus.ForwardB !== 2'd3) begin n_fail++; $display("FAIL lw_imm_fb: got %0d exp 3", bus.ForwardB); end
    set_id(1'b1, 5'd5, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0);   // add r9, r5, r2
    #1;
    n_chk++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %0d exp 1", bus.stall); end
    n_chk++; if (bus.stall_count !== 16'd0) begin n_fail++; $display("FAIL lu_cnt0: got %0d exp 0", bus.stall_count); end
    tick();
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_once: got %0d exp 0", bus.stall); end
    n_chk++; if (bus.stall_count !== 16'd1) begin n_fail++; $display("FAIL lu_cnt1: got %0d exp 1", bus.stall_count); end
    n_chk++; if (bus.ForwardA !== 2'd0) begin n_fail++; $display("FAIL lu_bubble_fa: got %0d exp 0", bus.ForwardA); end
    tick();
    n_chk++; if (bus.ForwardA !== 2'd1) begin n_fail++; $display("FAIL lu_fa: got %0d exp 1", bus.ForwardA); end
    n_chk++; if (bus.ForwardB !== 2'd0) begin n_fail++; $display("FAIL lu_fb: got %0d exp 0", bus.ForwardB); end
    n_chk++; if (bus.stall_count !== 16'd1) begin n_fail++; $display("FAIL lu_cnt_hold: got %0d exp 1", bus.stall_count); end
    drain();
  endtask

  task automatic test_flush();
    set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1);   // lw r5
    tick();
    // consumer is itself an alusrc load of r6, so a wrong capture is visible
    set_id(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1);
    bus.flush = 1'b1;
    #1;
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL fl_stall: got %0d exp 0", bus.stall); end
    tick();
    bus.flush = 1'b0;
    set_id(1'b1, 5'd6, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    #1;
    n_chk++; if (bus.stall_count !== 16'd1) begin n_fail++; $display("FAIL fl_cnt: got %0d exp 1", bus.stall_count); end
    n_chk++; if (bus.ForwardB !== 2'd0) begin n_fail++; $display("FAIL fl_bubble_fb: got %0d exp 0", bus.ForwardB); end
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL fl_bubble_stall: got %0d exp 0", bus.stall); end
    drain();
  endtask

  task automatic test_r0();
    set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);   // add r0
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    n_chk++; if (bus.ForwardA !== 2'd0) begin n_fail++; $display("FAIL r0_mem_fa: got %0d exp 0", bus.ForwardA); end
    n_chk++; if (bus.ForwardB !== 2'd0) begin n_fail++; $display("FAIL r0_mem_fb: got %0d exp 0", bus.ForwardB); end
    nop();
    tick();
    n_chk++; if (bus.ForwardA !== 2'd0) begin n_fail++; $display("FAIL r0_wb_fa: got %0d exp 0", bus.ForwardA); end
    drain();
    set_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);   // lw r0
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    #1;
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall: got %0d exp 0", bus.stall); end
    drain();
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);   // add r3
    tick();
    set_id(1'b1, 5'd1, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1);   // addi with rt == r3
    tick();
    n_chk++; if (bus.ForwardB !== 2'd3) begin n_fail++; $display("FAIL imm_fb: got %0d exp 3", bus.ForwardB); end
    n_chk++; if (bus.ForwardA !== 2'd0) begin n_fail++; $display("FAIL imm_fa: got %0d exp 0", bus.ForwardA); end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1);   // lw r5
    tick();
    set_id(1'b1, 5'd5, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0);
    #1;
    n_chk++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL rs_pre_stall: got %0d exp 1", bus.stall); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rs_stall: got %0d exp 0", bus.stall); end
    n_chk++; if (bus.ForwardA !== 2'd0) begin n_fail++; $display("FAIL rs_fa: got %0d exp 0", bus.ForwardA); end
    n_chk++; if (bus.ForwardB !== 2'd0) begin n_fail++; $display("FAIL rs_fb: got %0d exp 0", bus.ForwardB); end
    n_chk++; if (bus.stall_count !== 16'd0) begin n_fail++; $display("FAIL rs_cnt: got %0d exp 0", bus.stall_count); end
    @(negedge clk);
    rst_n = 1'b1;
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);   // add r3 on first edge after reset
    tick();
    set_id(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    n_chk++; if (bus.ForwardA !== 2'd2) begin n_fail++; $display("FAIL rs_first_edge_fa: got %0d exp 2", bus.ForwardA); end
    drain();
  endtask

  task automatic test_saturation();
    // lw r5 reading r5: stalls every other cycle
    sbus.id_valid = 1'b1; sbus.id_rs = 5'd5; sbus.id_rt = 5'd0; sbus.id_rd = 5'd5;
    sbus.id_regwrite = 1'b1; sbus.id_memread = 1'b1; sbus.id_alusrc = 1'b0; sbus.flush = 1'b0;
    repeat (4) tick();
    n_chk++; if (sbus.stall_count !== 2'd2) begin n_fail++; $display("FAIL sat_cnt2: got %0d exp 2", sbus.stall_count); end
    repeat (2) tick();
    n_chk++; if (sbus.stall_count !== 2'd3) begin n_fail++; $display("FAIL sat_cnt3: got %0d exp 3", sbus.stall_count); end
    repeat (4) tick();
    n_chk++; if (sbus.stall_count !== 2'd3) begin n_fail++; $display("FAIL sat_hold: got %0d exp 3", sbus.stall_count); end
    sbus.id_valid = 1'b0;
  endtask

  initial begin
    nop();
    bus.flush = 1'b0;
    sbus.id_valid = 1'b0; sbus.id_rs = '0; sbus.id_rt = '0; sbus.id_rd = '0;
    sbus.id_regwrite = 1'b0; sbus.id_memread = 1'b0; sbus.id_alusrc = 1'b0; sbus.flush = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_fwd_mem();
    test_fwd_wb();
    test_load_use();
    test_flush();
    test_r0();
    test_reset_mid_stall();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
